id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 90 +++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// a one-cycle load-use stall and a saturating stall counter.
module id_ex_stage #(
  parameter logic [3:0] OP_LOAD = 4'b1110,
  parameter logic [3:0] OP_NOWB = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [31:0] rsout,
  input  logic [31:0] rtout,
  input  logic        exm_wrt,
  input  logic [5:0]  exm_rd,
  input  logic [31:0] exm_data,
  input  logic        mwb_wrt,
  input  logic [5:0]  mwb_rd,
  input  logic [31:0] mwb_data,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_op,
  output logic [5:0]  ex_rd,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic        ex_wrt,
  output logic        ex_memread,
  output logic        stall,
  output logic [15:0] stall_cnt
);
  localparam logic [3:0] OP_STORE = 4'b0101;
  logic [3:0]  op;
  logic [5:0]  rd, rs, rt;
  logic        unused_bits;
  logic        bubble;
  logic [31:0] fwd_a, fwd_b;
  logic        valid_q, valid_d, wrt_q, wrt_d, memread_q, memread_d;
  logic [3:0]  op_q, op_d;
  logic [5:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [15:0] cnt_q, cnt_d;
  assign op          = instr[31:28];
  assign rd          = instr[27:22];
  assign rs          = instr[21:16];
  assign rt          = instr[15:10];
  assign unused_bits = ^instr[9:0];
  // The younger EX/MEM result wins over MEM/WB; register 0 forwards like any other.
  assign fwd_a = (exm_wrt && exm_rd == rs) ? exm_data : (mwb_wrt && mwb_rd == rs) ? mwb_data : rsout;
  assign fwd_b = (exm_wrt && exm_rd == rt) ? exm_data : (mwb_wrt && mwb_rd == rt) ? mwb_data : rtout;
  always_comb begin
    stall     = memread_q && instr_valid && (rd_q == rs || rd_q == rt) && !flush;
    bubble    = flush || stall || !instr_valid;
    valid_d   = !bubble;
    op_d      = bubble ? 4'd0 : op;
    rd_d      = bubble ? 6'd0 : rd;
    a_d       = bubble ? 32'd0 : fwd_a;
    b_d       = bubble ? 32'd0 : fwd_b;
    wrt_d     = !bubble && op != OP_NOWB && op != OP_STORE;
    memread_d = !bubble && op == OP_LOAD;
    cnt_d     = (stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      op_q      <= 4'd0;
      rd_q      <= 6'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      wrt_q     <= 1'b0;
      memread_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      wrt_q     <= wrt_d;
      memread_q <= memread_d;
      cnt_q     <= cnt_d;
    end
  end
  assign ex_valid   = valid_q;
  assign ex_op      = op_q;
  assign ex_rd      = rd_q;
  assign ex_a       = a_q;
  assign ex_b       = b_q;
  assign ex_wrt     = wrt_q;
  assign ex_memread = memread_q;
  assign stall_cnt  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; expected ID/EX contents are queued
// when an instruction is driven and popped after the capturing edge.
module tb_id_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0, rsout = '0, rtout = '0, exm_data = '0, mwb_data = '0;
  logic        instr_valid = 1'b0, exm_wrt = 1'b0, mwb_wrt = 1'b0, flush = 1'b0;
  logic [5:0]  exm_rd = '0, mwb_rd = '0;
  logic        ex_valid, ex_wrt, ex_memread, stall;
  logic [3:0]  ex_op;
  logic [5:0]  ex_rd;
  logic [31:0] ex_a, ex_b;
  logic [15:0] stall_cnt;
  logic [76:0] ex_all, e;
  logic [76:0] sb[$];
  int          errors = 0, checks = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .rsout(rsout), .rtout(rtout),
    .exm_wrt(exm_wrt), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wrt(mwb_wrt), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush(flush), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_wrt(ex_wrt), .ex_memread(ex_memread),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  assign ex_all = {ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_wrt, ex_memread};
  always #5 clk = ~clk;

  function automatic logic [76:0] ev(logic v, logic [3:0] o, logic [5:0] d, logic [31:0] a, logic [31:0] b, logic w, logic m);
    return {v, o, d, a, b, w, m};
  endfunction

  function automatic logic [31:0] mk(logic [3:0] o, logic [5:0] d, logic [5:0] s, logic [5:0] t);
    return {o, d, s, t, 10'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0; flush = 1'b0; exm_wrt = 1'b0; mwb_wrt = 1'b0;
  endtask

  task automatic test_reset();
    idle(); instr = mk(4'd1, 6'd7, 6'd1, 6'd2); instr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ex_all !== 77'd0) begin errors++; $display("FAIL reset_regs: got %h expected 0", ex_all); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", stall_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    idle();
    #2 rst_n = 1'b1;
    sb.push_back(77'd0); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL idle_bubble: got %h expected %h", ex_all, e); end
  endtask

  task automatic test_decode();
    logic [3:0] ops[4] = '{4'd5, 4'd0, 4'd14, 4'd3};
    logic       wr[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       mr[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    instr = mk(4'd1, 6'd7, 6'd1, 6'd2); instr_valid = 1'b1; rsout = 32'd3; rtout = 32'd4;
    sb.push_back(ev(1'b1, 4'd1, 6'd7, 32'd3, 32'd4, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL basic_add: got %h expected %h", ex_all, e); end
    for (int i = 0; i < 4; i++) begin
      instr = mk(ops[i], 6'd40, 6'd41, 6'd42); rsout = $urandom; rtout = $urandom;
      sb.push_back(ev(1'b1, ops[i], 6'd40, rsout, rtout, wr[i], mr[i])); tick();
      e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL decode_op%0d: got %h expected %h", ops[i], ex_all, e); end
    end
    idle(); sb.push_back(77'd0); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL invalid_bubble: got %h expected %h", ex_all, e); end
  endtask

  task automatic test_forward();
    instr = mk(4'd1, 6'd10, 6'd5, 6'd6); instr_valid = 1'b1; rsout = 32'd1; rtout = 32'd2;
    exm_wrt = 1'b1; exm_rd = 6'd5; exm_data = 32'd99; mwb_wrt = 1'b1; mwb_rd = 6'd5; mwb_data = 32'd42;
    sb.push_back(ev(1'b1, 4'd1, 6'd10, 32'd99, 32'd2, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL fwd_exm_prio: got %h expected %h", ex_all, e); end
    exm_wrt = 1'b0;
    sb.push_back(ev(1'b1, 4'd1, 6'd10, 32'd42, 32'd2, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL fwd_mwb: got %h expected %h", ex_all, e); end
    instr = mk(4'd2, 6'd11, 6'd7, 6'd9); exm_wrt = 1'b1; exm_rd = 6'd7; exm_data = 32'd55; mwb_rd = 6'd9;
    sb.push_back(ev(1'b1, 4'd2, 6'd11, 32'd55, 32'd42, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL fwd_ab: got %h expected %h", ex_all, e); end
    instr = mk(4'd1, 6'd12, 6'd0, 6'd0); exm_rd = 6'd0; exm_data = 32'd77; mwb_rd = 6'd0; mwb_data = 32'd88;
    sb.push_back(ev(1'b1, 4'd1, 6'd12, 32'd77, 32'd77, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL fwd_r0: got %h expected %h", ex_all, e); end
    exm_wrt = 1'b0; mwb_wrt = 1'b0;
    sb.push_back(ev(1'b1, 4'd1, 6'd12, 32'd1, 32'd2, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL fwd_none: got %h expected %h", ex_all, e); end
    idle();
  endtask

  task automatic test_load_use();
    instr = mk(4'd14, 6'd3, 6'd1, 6'd2); instr_valid = 1'b1; rsout = 32'd10; rtout = 32'd11;
    sb.push_back(ev(1'b1, 4'd14, 6'd3, 32'd10, 32'd11, 1'b1, 1'b1)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL lu_load: got %h expected %h", ex_all, e); end
    instr = mk(4'd1, 6'd8, 6'd3, 6'd4); rsout = 32'd20; rtout = 32'd21;
    #1 checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_hi: got %b expected 1", stall); end
    sb.push_back(77'd0); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL lu_bubble: got %h expected %h", ex_all, e); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_lo: got %b expected 0", stall); end
    sb.push_back(ev(1'b1, 4'd1, 6'd8, 32'd20, 32'd21, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL lu_add: got %h expected %h", ex_all, e); end
    instr = mk(4'd14, 6'd4, 6'd1, 6'd2);
    sb.push_back(ev(1'b1, 4'd14, 6'd4, 32'd20, 32'd21, 1'b1, 1'b1)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL lu_load_rt: got %h expected %h", ex_all, e); end
    instr = mk(4'd1, 6'd9, 6'd1, 6'd4);
    #1 checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rt_stall: got %b expected 1", stall); end
    sb.push_back(77'd0); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL lu_rt_bubble: got %h expected %h", ex_all, e); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_rt_cnt: got %0d expected 2", stall_cnt); end
    sb.push_back(ev(1'b1, 4'd1, 6'd9, 32'd20, 32'd21, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL lu_rt_add: got %h expected %h", ex_all, e); end
    idle();
  endtask

  task automatic test_flush();
    instr = mk(4'd14, 6'd3, 6'd1, 6'd2); instr_valid = 1'b1; rsout = 32'd5; rtout = 32'd6;
    sb.push_back(ev(1'b1, 4'd14, 6'd3, 32'd5, 32'd6, 1'b1, 1'b1)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL fl_load: got %h expected %h", ex_all, e); end
    instr = mk(4'd1, 6'd8, 6'd3, 6'd4); flush = 1'b1;
    #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b expected 0", stall); end
    sb.push_back(77'd0); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL fl_bubble: got %h expected %h", ex_all, e); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL fl_cnt: got %0d expected 2", stall_cnt); end
    flush = 1'b0; instr = mk(4'd14, 6'd3, 6'd1, 6'd2);
    sb.push_back(ev(1'b1, 4'd14, 6'd3, 32'd5, 32'd6, 1'b1, 1'b1)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL inv_load: got %h expected %h", ex_all, e); end
    instr = mk(4'd1, 6'd8, 6'd3, 6'd4); instr_valid = 1'b0;
    #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL inv_stall: got %b expected 0", stall); end
    sb.push_back(77'd0); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL inv_hazard_bubble: got %h expected %h", ex_all, e); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
    logic [3:0] o;
    logic [5:0] d, s, t;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = ops[$urandom_range(0, 4)];
      d = 6'($urandom_range(0, 7)); s = 6'($urandom_range(0, 7)); t = 6'($urandom_range(0, 7));
      instr = mk(o, d, s, t); instr_valid = ($urandom_range(0, 5) != 0);
      rsout = $urandom; rtout = $urandom; exm_data = $urandom; mwb_data = $urandom;
      exm_wrt = 1'($urandom_range(0, 1)); mwb_wrt = 1'($urandom_range(0, 1));
      exm_rd = 6'($urandom_range(0, 7)); mwb_rd = 6'($urandom_range(0, 7));
      a = (exm_wrt && exm_rd == s) ? exm_data : (mwb_wrt && mwb_rd == s) ? mwb_data : rsout;
      b = (exm_wrt && exm_rd == t) ? exm_data : (mwb_wrt && mwb_rd == t) ? mwb_data : rtout;
      sb.push_back(instr_valid ? ev(1'b1, o, d, a, b, o != 4'd0 && o != 4'd5, 1'b0) : 77'd0);
      tick();
      e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL b2b_%0d: got %h expected %h", i, ex_all, e); end
    end
    idle();
  endtask

  task automatic test_stall_sat();
    force dut.cnt_q = 16'hFFFD;
    for (int k = 0; k < 3; k++) begin
      instr = mk(4'd14, 6'd3, 6'd1, 6'd2); instr_valid = 1'b1; rsout = 32'd1; rtout = 32'd2;
      sb.push_back(ev(1'b1, 4'd14, 6'd3, 32'd1, 32'd2, 1'b1, 1'b1)); tick();
      if (k == 0) release dut.cnt_q;
      e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL sat_load%0d: got %h expected %h", k, ex_all, e); end
      instr = mk(4'd1, 6'd8, 6'd3, 6'd4);
      sb.push_back(77'd0); tick();
      e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL sat_bubble%0d: got %h expected %h", k, ex_all, e); end
      checks++; if (stall_cnt !== (k == 0 ? 16'hFFFE : 16'hFFFF)) begin errors++; $display("FAIL sat_cnt%0d: got %h expected %h", k, stall_cnt, (k == 0 ? 16'hFFFE : 16'hFFFF)); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    instr = mk(4'd1, 6'd7, 6'd1, 6'd2); instr_valid = 1'b1; rsout = 32'd3; rtout = 32'd4;
    sb.push_back(ev(1'b1, 4'd1, 6'd7, 32'd3, 32'd4, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL ar_capture: got %h expected %h", ex_all, e); end
    #2 rst_n = 1'b0;
    #1 checks++; if (ex_all !== 77'd0) begin errors++; $display("FAIL ar_regs: got %h expected 0", ex_all); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt: got %h expected 0", stall_cnt); end
    rst_n = 1'b1;
    instr = mk(4'd14, 6'd3, 6'd1, 6'd2);
    sb.push_back(ev(1'b1, 4'd14, 6'd3, 32'd3, 32'd4, 1'b1, 1'b1)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL ar_load: got %h expected %h", ex_all, e); end
    instr = mk(4'd1, 6'd8, 6'd3, 6'd4); rsout = 32'd30; rtout = 32'd31;
    #1 checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ar_stall_hi: got %b expected 1", stall); end
    #1 rst_n = 1'b0;
    #1 checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_stall_rst: got %b expected 0", stall); end
    rst_n = 1'b1;
    sb.push_back(ev(1'b1, 4'd1, 6'd8, 32'd30, 32'd31, 1'b1, 1'b0)); tick();
    e = sb.pop_front(); checks++; if (ex_all !== e) begin errors++; $display("FAIL ar_resume: got %h expected %h", ex_all, e); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL ar_resume_cnt: got %0d expected 0", stall_cnt); end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_forward();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_stall_sat();
    test_async_reset();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
